relax_osc_freq_meter: RTL
=========================

// Module: relax_osc_freq_meter
// PURPOSE
// - Multi-channel digital front end for the relaxation oscillator macros: enables up to NUM_CH oscillators,
//   synchronises their comparator outputs, counts rising edges over a programmable gate window.
// - Results are latched per channel for readout by the TT digital wrapper via ui_in/uo_out.
// - Adds single-shot and continuous modes, a settle delay, saturation/overflow and abort.
// PARAMETERS
// - NUM_CH      4   number of oscillator channels (1..8)
// - CNT_W       16  edge-count width per channel
// - GATE_W      20  gate-length width, in clk cycles
// - SETTLE_CYC  16  cycles between osc_en rising and gate opening (>=1)
// - SYNC_STG    2   synchroniser flops per osc input (>=2)
// PORTS
// - clk       in   1                      system clock
// - rst       in   1                      asynchronous, active-high reset
// - osc_in    in   NUM_CH                 raw comparator outputs, asynchronous to clk
// - ch_mask   in   NUM_CH                 channels to enable/measure; sampled at start
// - gate_len  in   GATE_W                 gate window length in cycles; 0 treated as 1; sampled at start
// - cont      in   1                      1 = continuous re-measure, 0 = single shot; sampled at start
// - start     in   1                      single-cycle request, honoured only in IDLE
// - abort     in   1                      stop measurement, return to IDLE
// - rd_sel    in   $clog2(NUM_CH) (min 1) result register select
// - osc_en    out  NUM_CH                 enable to analog oscillators
// - busy      out  1                      high in any state other than IDLE
// - done      out  1                      one-cycle pulse when results updated
// - rd_data   out  CNT_W                  latched count of channel rd_sel (combinational mux)
// - rd_ovf    out  1                      overflow flag of channel rd_sel
// BEHAVIOUR
// - Reset: state IDLE; osc_en=0, busy=0, done=0; all result registers, ovf flags, counters, synchronisers 0.
// - Input path: osc_in -> SYNC_STG flops -> prev flop; edge = sync & ~prev; prev always tracks, even in IDLE.
//   Latency from osc_in transition to counted edge: SYNC_STG+1 cycles.
// - FSM IDLE -> SETTLE -> GATE -> LATCH:
//   IDLE: start=1 -> capture ch_mask, gate_len, cont; go SETTLE. start with ch_mask=0 still runs (counts 0).
//   SETTLE: osc_en=captured mask; stays exactly SETTLE_CYC cycles; counters held 0.
//   GATE: exactly max(gate_len,1) cycles; each enabled channel increments on edge; masked channels stay 0.
//   LATCH: one cycle; counts+ovf copied to result regs; done=1 same cycle; counters cleared.
//     cont=1 -> GATE (osc_en stays on, no settle); cont=0 -> IDLE, osc_en=0 next cycle.
// - Edges detected in LATCH cycle are not counted (1-cycle dead time per window in continuous mode).
// - Edge on the last GATE cycle is counted.
// - Saturation: counter at 2^CNT_W-1 holds; further edge sets channel ovf; ovf cleared with counter in LATCH.
// - abort (any state but IDLE): IDLE next cycle, osc_en=0, no done, result regs keep previous values.
//   abort has priority over start and over LATCH completion.
// - start while busy ignored; new ch_mask/gate_len/cont take effect only at next accepted start.
// - Result regs of masked channels are written 0 in LATCH.
// - rd_sel >= NUM_CH: rd_data=0, rd_ovf=0.
// TESTING
// - Reset mid-GATE with osc running -> all outputs 0 same cycle, busy=0, rd_data=0 for every rd_sel.
// - ch_mask=4'b0001, gate_len=1000, ch0 toggling period 10 clk -> done after 16+1000+1 cycles, rd_data(0)=100 +/-1.
// - CNT_W=4 build, gate_len=200, period 4 clk -> rd_data=15, rd_ovf=1; next window period 40 -> rd_ovf=0.
// - cont=1, gate_len=50 -> done pulses every 51 cycles, osc_en held; abort -> IDLE next cycle, last result kept.
// - gate_len=0, edge 1 cycle into GATE -> count 1, done after SETTLE_CYC+2 cycles; start during busy ignored.
// - ch_mask=4'b1010 with all inputs toggling -> rd_data(0)=rd_data(2)=0, osc_en=4'b1010 while busy.

Source files
------------

// File: rtl/relax_osc_freq_meter.sv
`default_nettype none
// ============================================================================
// Module      : relax_osc_freq_meter
// Description : Multi-channel relaxation-oscillator front end. Synchronises
//               comparator outputs, counts rising edges over a gate window
//               and latches per-channel counts for readout.
// Revision    : 1.0 - initial release
// ============================================================================
module relax_osc_freq_meter #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int GATE_W     = 20,
    parameter int SETTLE_CYC = 16,
    parameter int SYNC_STG   = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [NUM_CH-1:0]                             osc_in,
    input  logic [NUM_CH-1:0]                             ch_mask,
    input  logic [GATE_W-1:0]                             gate_len,
    input  logic                                          cont,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] rd_sel,
    output logic [NUM_CH-1:0]                             osc_en,
    output logic                                          busy,
    output logic                                          done,
    output logic [CNT_W-1:0]                              rd_data,
    output logic                                          rd_ovf
);

    localparam int c_sw = $clog2(SETTLE_CYC + 1);
    localparam int c_tw = (GATE_W > c_sw) ? GATE_W : c_sw;

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_gate   = 2'd2;
    localparam logic [1:0] c_st_latch  = 2'd3;

    localparam logic [c_tw-1:0] c_settle_last = c_tw'(SETTLE_CYC - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [c_tw-1:0]   r_tmr;
    logic [NUM_CH-1:0] r_mask;
    logic [GATE_W-1:0] r_gate_len;
    logic              r_cont;
    logic [NUM_CH-1:0] r_sync [SYNC_STG];
    logic [NUM_CH-1:0] r_prev;
    logic [NUM_CH-1:0] w_edge;
    logic [GATE_W-1:0] w_gate_eff;
    logic [c_tw-1:0]   w_gate_last;
    logic [NUM_CH-1:0] w_osc_en;
    logic              w_busy;
    logic              w_done;
    logic [CNT_W-1:0]  w_res     [NUM_CH];
    logic              w_res_ovf [NUM_CH];
    logic [CNT_W-1:0]  w_rd_data;
    logic              w_rd_ovf;

    // Synchroniser and previous-value flop run in every state so that an
    // edge straddling the gate opening is judged against a valid history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STG; k++) r_sync[k] <= '0;
            r_prev <= '0;
        end else begin
            r_sync[0] <= osc_in;
            for (int k = 1; k < SYNC_STG; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    assign w_edge      = r_sync[SYNC_STG-1] & ~r_prev;
    assign w_gate_eff  = (r_gate_len == '0) ? GATE_W'(1) : r_gate_len;
    assign w_gate_last = c_tw'(w_gate_eff) - c_tw'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mask     <= '0;
            r_gate_len <= '0;
            r_cont     <= 1'b0;
        end else if (r_state == c_st_idle && start) begin
            r_mask     <= ch_mask;
            r_gate_len <= gate_len;
            r_cont     <= cont;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        r_tmr <= '0;
        else if (w_state_nxt != r_state) r_tmr <= '0;
        else if (r_state != c_st_idle)   r_tmr <= r_tmr + c_tw'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_st_idle;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (r_state != c_st_idle && abort) begin
            w_state_nxt = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:   if (start) w_state_nxt = c_st_settle;
                c_st_settle: if (r_tmr == c_settle_last) w_state_nxt = c_st_gate;
                c_st_gate:   if (r_tmr == w_gate_last) w_state_nxt = c_st_latch;
                c_st_latch:  w_state_nxt = r_cont ? c_st_gate : c_st_idle;
                default:     w_state_nxt = c_st_idle;
            endcase
        end
    end

    always_comb begin
        w_busy   = (r_state != c_st_idle);
        w_osc_en = w_busy ? r_mask : '0;
        w_done   = (r_state == c_st_latch) && !abort;
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic             r_ovf;
            logic [CNT_W-1:0] r_res;
            logic             r_res_ovf;

            // Counter saturates at all-ones; any further edge flags overflow.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (r_state != c_st_gate) begin
                    r_cnt <= '0;
                    r_ovf <= 1'b0;
                end else if (w_edge[i] && r_mask[i]) begin
                    if (&r_cnt) r_ovf <= 1'b1;
                    else        r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_res     <= '0;
                    r_res_ovf <= 1'b0;
                end else if (w_done) begin
                    r_res     <= r_mask[i] ? r_cnt : '0;
                    r_res_ovf <= r_mask[i] & r_ovf;
                end
            end

            assign w_res[i]     = r_res;
            assign w_res_ovf[i] = r_res_ovf;
        end
    endgenerate

    always_comb begin
        w_rd_data = '0;
        w_rd_ovf  = 1'b0;
        if (int'(rd_sel) < NUM_CH) begin
            w_rd_data = w_res[rd_sel];
            w_rd_ovf  = w_res_ovf[rd_sel];
        end
    end

    assign osc_en  = w_osc_en;
    assign busy    = w_busy;
    assign done    = w_done;
    assign rd_data = w_rd_data;
    assign rd_ovf  = w_rd_ovf;

endmodule
`default_nettype wire
